// File: rtl/sdram_burst_sequencer.sv
// Burst engine between cache/write-buffer control and the SDRAM controller; drives req/grant, beat index and beat strobes.
// Latency: request to sdr_req 1 cycle; write beats 0 cycles (TxD same cycle as rdy); read beats 1 cycle (RxD registered from vld).
// Backpressure: gaps in sdr_wdata_rdy / sdr_rdata_vld stall Count; a watchdog aborts a stalled ARB/WBURST/RBURST with Done+Err.
module sdram_burst_sequencer #(
  parameter int BURST_LEN = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 63
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] wdata_in,
  output logic [2:0]    Count,
  output logic          mSDR_TxD,
  output logic          mSDR_RxD,
  output logic [DW-1:0] mSDR_RData,
  output logic          mSDR_Done,
  output logic          mSDR_Err,
  output logic          sdr_req,
  output logic          sdr_rnw,
  output logic [AW-1:0] sdr_addr,
  input  logic          sdr_gnt,
  input  logic          sdr_wdata_rdy,
  output logic [DW-1:0] sdr_wdata,
  input  logic          sdr_rdata_vld,
  input  logic [DW-1:0] sdr_rdata
);

  typedef enum logic [2:0] {IDLE, ARB, WBURST, RBURST, DONE} state_t;

  // Bursts are aligned to BURST_LEN words of 4 bytes each.
  localparam int            ALIGN_BITS = $clog2(BURST_LEN) + 2;
  localparam logic [AW-1:0] ALIGN_MASK = ~((AW'(1) << ALIGN_BITS) - AW'(1));
  localparam logic [2:0]    LAST_BEAT  = 3'(BURST_LEN - 1);
  localparam logic [5:0]    WD_LIMIT   = 6'(TIMEOUT);

  state_t     state;
  logic [5:0] wd_cnt;
  logic       waiting;
  logic       progress;
  logic       wd_expire;

  // Write beats are accepted combinationally so Count and TxD line up with rdy.
  assign mSDR_TxD  = (state == WBURST) && sdr_wdata_rdy;
  assign sdr_wdata = wdata_in;
  assign wd_expire = (wd_cnt + 6'd1) == WD_LIMIT;

  // Classify the current cycle for the watchdog: waiting state, and whether it made progress.
  always_comb begin
    waiting  = 1'b0;
    progress = 1'b0;
    unique case (state)
      ARB:     begin waiting = 1'b1; progress = sdr_gnt;  end
      WBURST:  begin waiting = 1'b1; progress = mSDR_TxD; end
      RBURST:  begin waiting = 1'b1; progress = mSDR_RxD; end
      default: begin waiting = 1'b0; progress = 1'b0;     end
    endcase
  end

  // Sequencer FSM with registered request, read strobe/data, completion pulses and watchdog.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      Count      <= 3'd0;
      sdr_req    <= 1'b0;
      sdr_rnw    <= 1'b1;
      sdr_addr   <= '0;
      mSDR_RxD   <= 1'b0;
      mSDR_RData <= '0;
      mSDR_Done  <= 1'b0;
      mSDR_Err   <= 1'b0;
      wd_cnt     <= 6'd0;
    end else begin
      mSDR_Done <= 1'b0;
      mSDR_Err  <= 1'b0;

      unique case (state)
        IDLE: begin
          mSDR_RxD <= 1'b0;
          wd_cnt   <= 6'd0;
          if (req_wr || req_rd) begin
            sdr_addr <= req_addr & ALIGN_MASK;
            // Write-back wins so a dirty line is flushed before its refill.
            sdr_rnw  <= ~req_wr;
            sdr_req  <= 1'b1;
            state    <= ARB;
          end
        end

        ARB: begin
          if (sdr_gnt) begin
            sdr_req <= 1'b0;
            wd_cnt  <= 6'd0;
            state   <= sdr_rnw ? RBURST : WBURST;
          end else begin
            wd_cnt <= wd_cnt + 6'd1;
          end
        end

        WBURST: begin
          if (mSDR_TxD) begin
            wd_cnt <= 6'd0;
            if (Count == LAST_BEAT) begin
              Count     <= 3'd0;
              mSDR_Done <= 1'b1;
              state     <= DONE;
            end else begin
              Count <= Count + 3'd1;
            end
          end else begin
            wd_cnt <= wd_cnt + 6'd1;
          end
        end

        RBURST: begin
          if (sdr_rdata_vld) begin
            mSDR_RData <= sdr_rdata;
          end
          if (mSDR_RxD) begin
            wd_cnt <= 6'd0;
            if (Count == LAST_BEAT) begin
              // Last beat shown: any further vld from the controller is dropped.
              Count     <= 3'd0;
              mSDR_RxD  <= 1'b0;
              mSDR_Done <= 1'b1;
              state     <= DONE;
            end else begin
              Count    <= Count + 3'd1;
              mSDR_RxD <= sdr_rdata_vld;
            end
          end else begin
            wd_cnt   <= wd_cnt + 6'd1;
            mSDR_RxD <= sdr_rdata_vld;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Stalled too long in a waiting state: abandon the transaction and report it.
      if (waiting && !progress && wd_expire) begin
        state     <= DONE;
        sdr_req   <= 1'b0;
        Count     <= 3'd0;
        mSDR_RxD  <= 1'b0;
        mSDR_Done <= 1'b1;
        mSDR_Err  <= 1'b1;
        wd_cnt    <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Directed bench for sdram_burst_sequencer: per-cycle vector tables plus a hand-written watchdog sequence.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
// Expected values are hand-computed per cycle from the burst protocol.
module tb_sdram_burst_sequencer;

  logic        Clk;
  logic        Reset;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] wdata_in;
  logic [2:0]  Count;
  logic        mSDR_TxD;
  logic        mSDR_RxD;
  logic [31:0] mSDR_RData;
  logic        mSDR_Done;
  logic        mSDR_Err;
  logic        sdr_req;
  logic        sdr_rnw;
  logic [31:0] sdr_addr;
  logic        sdr_gnt;
  logic        sdr_wdata_rdy;
  logic [31:0] sdr_wdata;
  logic        sdr_rdata_vld;
  logic [31:0] sdr_rdata;

  int total = 0;
  int bad   = 0;

  sdram_burst_sequencer #(
    .BURST_LEN(4),
    .AW       (32),
    .DW       (32),
    .TIMEOUT  (63)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .wdata_in     (wdata_in),
    .Count        (Count),
    .mSDR_TxD     (mSDR_TxD),
    .mSDR_RxD     (mSDR_RxD),
    .mSDR_RData   (mSDR_RData),
    .mSDR_Done    (mSDR_Done),
    .mSDR_Err     (mSDR_Err),
    .sdr_req      (sdr_req),
    .sdr_rnw      (sdr_rnw),
    .sdr_addr     (sdr_addr),
    .sdr_gnt      (sdr_gnt),
    .sdr_wdata_rdy(sdr_wdata_rdy),
    .sdr_wdata    (sdr_wdata),
    .sdr_rdata_vld(sdr_rdata_vld),
    .sdr_rdata    (sdr_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One cycle of stimulus and the outputs expected during that cycle.
  typedef struct {
    logic [5:0]  in_bits;  // {rst, rd, wr, gnt, rdy, vld}
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  e_bits;   // {req, rnw, txd, rxd}
    logic [2:0]  e_cnt;
    logic        e_done;
    logic [31:0] e_rdata;
    logic [31:0] e_addr;
  } vec_t;

  vec_t ta[$];
  vec_t tb_rst[$];

  function automatic vec_t mk(input logic [5:0] in_bits, input logic [31:0] addr, input logic [31:0] rdata,
                              input logic [3:0] e_bits, input logic [2:0] e_cnt, input logic e_done,
                              input logic [31:0] e_rdata, input logic [31:0] e_addr);
    vec_t v;
    v.in_bits = in_bits;
    v.addr    = addr;
    v.rdata   = rdata;
    v.e_bits  = e_bits;
    v.e_cnt   = e_cnt;
    v.e_done  = e_done;
    v.e_rdata = e_rdata;
    v.e_addr  = e_addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [8:0] act_ctl;
    logic [8:0] exp_ctl;
    Reset         = v.in_bits[5];
    req_rd        = v.in_bits[4];
    req_wr        = v.in_bits[3];
    sdr_gnt       = v.in_bits[2];
    sdr_wdata_rdy = v.in_bits[1];
    sdr_rdata_vld = v.in_bits[0];
    req_addr      = v.addr;
    sdr_rdata     = v.rdata;
    wdata_in      = 32'hC0DE_0000 + 32'(idx);
    @(negedge Clk);
    act_ctl = {sdr_req, sdr_rnw, mSDR_TxD, mSDR_RxD, Count, mSDR_Done, mSDR_Err};
    exp_ctl = {v.e_bits, v.e_cnt, v.e_done, 1'b0};
    chk($sformatf("%s[%0d] {req,rnw,txd,rxd,cnt,done,err}", tag, idx), 32'(act_ctl), 32'(exp_ctl));
    chk($sformatf("%s[%0d] sdr_wdata", tag, idx), sdr_wdata, wdata_in);
    chk($sformatf("%s[%0d] sdr_addr", tag, idx), sdr_addr, v.e_addr);
    if (v.e_bits[0]) begin
      chk($sformatf("%s[%0d] mSDR_RData", tag, idx), mSDR_RData, v.e_rdata);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int hi;

    // Write burst at 0x1234, grant after 2 ARB cycles, rdy always high.
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b0100, 3'd0, 1'b0, 32'h0, 32'h0));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b1000, 3'd0, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b1000, 3'd0, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001110, 32'h1234, 32'h0, 4'b1000, 3'd0, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b0010, 3'd0, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b0010, 3'd1, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b0010, 3'd2, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b001010, 32'h1234, 32'h0, 4'b0010, 3'd3, 1'b0, 32'h0, 32'h1230));
    ta.push_back(mk(6'b000010, 32'h0,    32'h0, 4'b0000, 3'd0, 1'b1, 32'h0, 32'h1230));
    ta.push_back(mk(6'b000000, 32'h0,    32'h0, 4'b0000, 3'd0, 1'b0, 32'h0, 32'h1230));
    // Read burst with vld pattern 1,1,0,1,1 then a stray vld after the last beat.
    ta.push_back(mk(6'b010000, 32'hABCF, 32'h0,         4'b0000, 3'd0, 1'b0, 32'h0,         32'h1230));
    ta.push_back(mk(6'b010100, 32'hABCF, 32'h0,         4'b1100, 3'd0, 1'b0, 32'h0,         32'hABC0));
    ta.push_back(mk(6'b010011, 32'h0,    32'hA0A0A0A0,  4'b0100, 3'd0, 1'b0, 32'h0,         32'hABC0));
    ta.push_back(mk(6'b010011, 32'h0,    32'hB1B1B1B1,  4'b0101, 3'd0, 1'b0, 32'hA0A0A0A0,  32'hABC0));
    ta.push_back(mk(6'b010010, 32'h0,    32'h0,         4'b0101, 3'd1, 1'b0, 32'hB1B1B1B1,  32'hABC0));
    ta.push_back(mk(6'b010011, 32'h0,    32'hC2C2C2C2,  4'b0100, 3'd2, 1'b0, 32'h0,         32'hABC0));
    ta.push_back(mk(6'b010011, 32'h0,    32'hD3D3D3D3,  4'b0101, 3'd2, 1'b0, 32'hC2C2C2C2,  32'hABC0));
    ta.push_back(mk(6'b010011, 32'h0,    32'hE4E4E4E4,  4'b0101, 3'd3, 1'b0, 32'hD3D3D3D3,  32'hABC0));
    ta.push_back(mk(6'b000010, 32'h0,    32'h0,         4'b0100, 3'd0, 1'b1, 32'h0,         32'hABC0));
    ta.push_back(mk(6'b000000, 32'h0,    32'h0,         4'b0100, 3'd0, 1'b0, 32'h0,         32'hABC0));
    // Both requests high: write first (with a rdy gap), then the held read runs.
    ta.push_back(mk(6'b011000, 32'h100, 32'h0,  4'b0100, 3'd0, 1'b0, 32'h0,  32'hABC0));
    ta.push_back(mk(6'b011100, 32'h100, 32'h0,  4'b1000, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b011010, 32'h100, 32'h0,  4'b0010, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b011000, 32'h100, 32'h0,  4'b0000, 3'd1, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b011010, 32'h100, 32'h0,  4'b0010, 3'd1, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b011010, 32'h100, 32'h0,  4'b0010, 3'd2, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b011010, 32'h100, 32'h0,  4'b0010, 3'd3, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b010010, 32'h100, 32'h0,  4'b0000, 3'd0, 1'b1, 32'h0,  32'h100));
    ta.push_back(mk(6'b010000, 32'h100, 32'h0,  4'b0000, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b010000, 32'h100, 32'h0,  4'b1100, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b010100, 32'h100, 32'h0,  4'b1100, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b010001, 32'h0,   32'h11, 4'b0100, 3'd0, 1'b0, 32'h0,  32'h100));
    ta.push_back(mk(6'b010001, 32'h0,   32'h22, 4'b0101, 3'd0, 1'b0, 32'h11, 32'h100));
    ta.push_back(mk(6'b010001, 32'h0,   32'h33, 4'b0101, 3'd1, 1'b0, 32'h22, 32'h100));
    ta.push_back(mk(6'b010001, 32'h0,   32'h44, 4'b0101, 3'd2, 1'b0, 32'h33, 32'h100));
    ta.push_back(mk(6'b010000, 32'h0,   32'h0,  4'b0101, 3'd3, 1'b0, 32'h44, 32'h100));
    ta.push_back(mk(6'b000000, 32'h0,   32'h0,  4'b0100, 3'd0, 1'b1, 32'h0,  32'h100));
    ta.push_back(mk(6'b000000, 32'h0,   32'h0,  4'b0100, 3'd0, 1'b0, 32'h0,  32'h100));

    // Reset after write beat 1, then a clean 4-beat write.
    tb_rst.push_back(mk(6'b001110, 32'h2000, 32'h0, 4'b0000, 3'd0, 1'b0, 32'h0, 32'h40));
    tb_rst.push_back(mk(6'b001110, 32'h2000, 32'h0, 4'b1000, 3'd0, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd0, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd1, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b101010, 32'h2000, 32'h0, 4'b0010, 3'd2, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b000010, 32'h0,    32'h0, 4'b0100, 3'd0, 1'b0, 32'h0, 32'h0));
    tb_rst.push_back(mk(6'b000000, 32'h0,    32'h0, 4'b0100, 3'd0, 1'b0, 32'h0, 32'h0));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0100, 3'd0, 1'b0, 32'h0, 32'h0));
    tb_rst.push_back(mk(6'b001110, 32'h2000, 32'h0, 4'b1000, 3'd0, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd0, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd1, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd2, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b001010, 32'h2000, 32'h0, 4'b0010, 3'd3, 1'b0, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b000000, 32'h0,    32'h0, 4'b0000, 3'd0, 1'b1, 32'h0, 32'h2000));
    tb_rst.push_back(mk(6'b000000, 32'h0,    32'h0, 4'b0000, 3'd0, 1'b0, 32'h0, 32'h2000));

    // Reset state.
    Reset         = 1'b1;
    req_rd        = 1'b0;
    req_wr        = 1'b0;
    req_addr      = 32'h0;
    wdata_in      = 32'h0;
    sdr_gnt       = 1'b0;
    sdr_wdata_rdy = 1'b1;
    sdr_rdata_vld = 1'b0;
    sdr_rdata     = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset Count",      32'(Count),      32'h0);
    chk("reset sdr_req",    32'(sdr_req),    32'h0);
    chk("reset sdr_rnw",    32'(sdr_rnw),    32'h1);
    chk("reset sdr_addr",   sdr_addr,        32'h0);
    chk("reset mSDR_RxD",   32'(mSDR_RxD),   32'h0);
    chk("reset mSDR_TxD",   32'(mSDR_TxD),   32'h0);
    chk("reset mSDR_RData", mSDR_RData,      32'h0);
    chk("reset mSDR_Done",  32'(mSDR_Done),  32'h0);
    chk("reset mSDR_Err",   32'(mSDR_Err),   32'h0);

    for (int i = 0; i < ta.size(); i++) begin
      apply(ta[i], "burst", i);
    end

    // Watchdog: grant never arrives.
    Reset         = 1'b0;
    req_wr        = 1'b1;
    req_rd        = 1'b0;
    req_addr      = 32'h0000_004C;
    sdr_gnt       = 1'b0;
    sdr_wdata_rdy = 1'b0;
    sdr_rdata_vld = 1'b0;
    @(posedge Clk);
    #1;
    hi = 0;
    @(negedge Clk);
    while (sdr_req && hi < 100) begin
      hi++;
      @(negedge Clk);
    end
    chk("timeout req_high_cycles", 32'(hi),        32'd63);
    chk("timeout sdr_req",         32'(sdr_req),   32'h0);
    chk("timeout mSDR_Done",       32'(mSDR_Done), 32'h1);
    chk("timeout mSDR_Err",        32'(mSDR_Err),  32'h1);
    chk("timeout Count",           32'(Count),     32'h0);
    req_wr = 1'b0;
    @(negedge Clk);
    chk("after_timeout mSDR_Done", 32'(mSDR_Done), 32'h0);
    chk("after_timeout mSDR_Err",  32'(mSDR_Err),  32'h0);
    chk("after_timeout sdr_req",   32'(sdr_req),   32'h0);
    @(posedge Clk);
    #1;

    for (int i = 0; i < tb_rst.size(); i++) begin
      apply(tb_rst[i], "midreset", i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
